alu_secuencial: RTL and testbench

//  Parametrised successor of the 32-bit combinational ALU: WIDTH-bit datapath, registered result,

---
 rtl/alu_pkg.sv | 31 +++
 rtl/suma_c2_param.sv | 16 +
 rtl/alu_secuencial.sv | 151 +++++++++++++++
 tb/tb_alu_secuencial.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, FSM states and flag bundle for the sequential ALU
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_XOR = 4'b0011,
        OP_SLL = 4'b0100,
        OP_SRL = 4'b0101,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_SRA = 4'b1000,
        OP_MUL = 4'b1001,
        OP_NOR = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } alu_state_e;

    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/suma_c2_param.sv
// suma_c2_param: WIDTH-bit two's-complement adder with carry-out and signed overflow
module suma_c2_param #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign ovf = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_secuencial.sv
// alu_secuencial: registered ALU with valid/ready handshake and iterative shift-add multiply
module alu_secuencial
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             coutfin,
    output logic             z,
    output logic             n,
    output logic             ovf,
    output logic             busy
);

    alu_op_e            op;
    alu_state_e         state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mac_acc, mac_next;
    logic [WIDTH-1:0]   mcand_q, mcand_d, out_q, out_d, res, add_b, add_s, mac_m;
    logic [WIDTH:0]     mac_sum;
    logic [SHW-1:0]     sha;
    alu_flags_t         fl_q, fl_d, fl;
    logic               out_valid_q, out_valid_d, busy_q, busy_d;
    logic               add_cin, add_cout, add_ovf, accept;

    assign op       = alu_op_e'(ALU_Sel);
    assign sha      = B[SHW-1:0];
    assign in_ready = !rst && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign add_b    = (op == OP_ADD) ? B : ~B;
    assign add_cin  = (op != OP_ADD);

    suma_c2_param #(.WIDTH(WIDTH)) u_suma (
        .a    (A),
        .b    (add_b),
        .cin  (add_cin),
        .s    (add_s),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    // One shift-add step; the first step runs on the accept edge straight from the ports
    assign mac_acc  = (state_q == IDLE) ? {{WIDTH{1'b0}}, B} : acc_q;
    assign mac_m    = (state_q == IDLE) ? A : mcand_q;
    assign mac_sum  = {1'b0, mac_acc[2*WIDTH-1:WIDTH]} + {1'b0, mac_acc[0] ? mac_m : {WIDTH{1'b0}}};
    assign mac_next = {mac_sum, mac_acc[WIDTH-1:1]};

    // Single-cycle result and flags for the op presented on the inputs
    always_comb begin
        res = '0;
        unique case (op)
            OP_AND:  res = A & B;
            OP_OR:   res = A | B;
            OP_ADD:  res = add_s;
            OP_XOR:  res = A ^ B;
            OP_SLL:  res = A << sha;
            OP_SRL:  res = A >> sha;
            OP_SUB:  res = add_s;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, add_s[WIDTH-1] ^ add_ovf};
            OP_SRA:  res = $signed(A) >>> sha;
            OP_NOR:  res = ~(A | B);
            default: res = '0;
        endcase
        fl.c = (op == OP_ADD || op == OP_SUB) ? add_cout : 1'b0;
        fl.v = (op == OP_ADD || op == OP_SUB) ? add_ovf : 1'b0;
        fl.z = (res == '0);
        fl.n = res[WIDTH-1];
    end

    // Next-state: accept, multiply iterations, and output register hold/release
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        out_d       = out_q;
        fl_d        = fl_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q && !out_ready;
        unique case (state_q)
            IDLE: if (accept) begin
                if (op == OP_MUL) begin
                    state_d = MUL;
                    busy_d  = 1'b1;
                    cnt_d   = SHW'(1);
                    acc_d   = mac_next;
                    mcand_d = A;
                end else begin
                    out_d       = res;
                    fl_d        = fl;
                    out_valid_d = 1'b1;
                end
            end
            MUL: begin
                acc_d = mac_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH-1)) state_d = DONE;
            end
            DONE: begin
                out_d       = acc_q[WIDTH-1:0];
                fl_d        = '{c: |acc_q[2*WIDTH-1:WIDTH], z: (acc_q[WIDTH-1:0] == '0), n: acc_q[WIDTH-1], v: 1'b0};
                out_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            out_q       <= '0;
            fl_q        <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            out_q       <= out_d;
            fl_q        <= fl_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ALU_Out   = out_q;
    assign coutfin   = fl_q.c;
    assign z         = fl_q.z;
    assign n         = fl_q.n;
    assign ovf       = fl_q.v;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_secuencial.sv
// tb_alu_secuencial: random and directed checks of alu_secuencial against an arithmetic model
module tb_alu_secuencial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [3:0]  ALU_Sel = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] ALU_Out;
    logic        coutfin, z, n, ovf, busy;
    int          errors = 0;
    int          checks = 0;

    alu_secuencial #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ALU_Sel   (ALU_Sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALU_Out   (ALU_Out),
        .coutfin   (coutfin),
        .z         (z),
        .n         (n),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                         output logic [31:0] r, output logic c, output logic v);
        longint sa, sb, wide_s;
        logic [63:0] wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (s)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  begin
                wide = {32'b0, a} + {32'b0, b};
                r = wide[31:0];
                c = wide[32];
                wide_s = sa + sb;
                v = wide_s > 64'sd2147483647 || wide_s < -64'sd2147483648;
            end
            4'd3:  r = a ^ b;
            4'd4:  r = a << b[4:0];
            4'd5:  r = a >> b[4:0];
            4'd6:  begin
                r = a - b;
                c = a >= b;
                wide_s = sa - sb;
                v = wide_s > 64'sd2147483647 || wide_s < -64'sd2147483648;
            end
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  r = 32'(sa >>> b[4:0]);
            4'd9:  begin
                wide = {32'b0, a} * {32'b0, b};
                r = wide[31:0];
                c = |wide[63:32];
            end
            4'd12: r = ~(a | b);
            default: r = '0;
        endcase
    endtask

    // Issue one op with out_ready high, scramble inputs after accept, check latency and result
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
        logic [31:0] er;
        logic ec, ev;
        int k, lat;
        model(a, b, s, er, ec, ev);
        A = a;
        B = b;
        ALU_Sel = s;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = $urandom;
        B = $urandom;
        ALU_Sel = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (lat == 5) begin
                check({tag, "_busy"}, 64'(busy), 64'd1);
                check({tag, "_stall"}, 64'(in_ready), 64'd0);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), (s == 4'd9) ? 64'd33 : 64'd1);
        check({tag, "_out"}, 64'(ALU_Out), 64'(er));
        check({tag, "_flags"}, 64'({coutfin, z, n, ovf}), 64'({ec, er == 32'd0, er[31], ev}));
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        return ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
    endfunction

    initial begin
        #2;
        check("rst_outs", 64'({out_valid, ALU_Out, coutfin, z, n, ovf, busy}), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("idle_ready", 64'(in_ready), 64'd1);

        run_op("and", 32'd1, 32'd2, 4'b0000);
        check("and_z", 64'(z), 64'd1);
        run_op("bad", 32'd3, 32'd4, 4'b1111);
        check("bad_z", 64'(z), 64'd1);
        run_op("add_wrap", 32'hFFFFFFFF, 32'd1, 4'b0010);
        check("add_wrap_c", 64'({ALU_Out, coutfin}), 64'({32'd0, 1'b1}));
        run_op("add_ovf", 32'h7FFFFFFF, 32'd1, 4'b0010);
        check("add_ovf_v", 64'({ALU_Out, ovf, n}), 64'({32'h80000000, 2'b11}));
        run_op("sub", 32'd3, 32'd4, 4'b0110);
        check("sub_val", 64'({ALU_Out, coutfin}), 64'({32'hFFFFFFFF, 1'b0}));
        run_op("slt", 32'd3, 32'd4, 4'b0111);
        run_op("slt_neg", 32'hFFFFFFFF, 32'd1, 4'b0111);
        check("slt_neg_val", 64'(ALU_Out), 64'd1);
        run_op("sra", 32'h80000000, 32'd4, 4'b1000);
        check("sra_val", 64'(ALU_Out), 64'hF8000000);
        run_op("sll0", 32'h12345678, 32'h00000020, 4'b0100);
        run_op("mul_hi", 32'h00010000, 32'h00010000, 4'b1001);
        check("mul_hi_c", 64'({ALU_Out, coutfin, z}), 64'({32'd0, 2'b11}));
        run_op("mul", 32'd3, 32'd5, 4'b1001);
        check("mul_val", 64'(ALU_Out), 64'hF);

        for (int i = 0; i < 120; i++) run_op("rand", pick(), pick(), 4'($urandom_range(0, 15)));

        @(posedge clk);
        #1;
        out_ready = 1'b0;
        A = 32'd3;
        B = 32'd4;
        ALU_Sel = 4'b0010;
        in_valid = 1'b1;
        #1;
        check("bp_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        A = 32'd5;
        B = 32'd6;
        ALU_Sel = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", 64'({out_valid, ALU_Out, in_ready}), 64'({1'b1, 32'd7, 1'b0}));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp_release", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_next", 64'({out_valid, ALU_Out}), 64'({1'b1, 32'd3}));

        @(posedge clk);
        #1;
        A = 32'd7;
        B = 32'd9;
        ALU_Sel = 4'b1001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst", 64'({out_valid, ALU_Out, coutfin, z, n, ovf, busy, in_ready}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_op("post_rst", 32'd1, 32'd2, 4'b0010);
        check("post_rst_val", 64'(ALU_Out), 64'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
